checker_bus: RTL and testbench
==============================

# checker_bus

Simulation-side protocol checker for a single valid/ready request/response bus of the copperv core, such as the instruction or data memory port. It is instantiated beside the bus in the testbench, alongside the CPU checker. It is passive: it observes handshakes, tracks outstanding transactions and detects protocol violations. Errors are reported on registered, sticky outputs so the bench or a wrapping assertion can fail the run.

## Interface
- `payload_width`, 32: width of the request payload (address plus write data, concatenated by the instantiator).
- `max_outstanding`, 4: maximum number of accepted requests that may await a response; must be ≥1.
- `timeout_cycles`, 256: cycles a non-empty outstanding count may go without a response handshake; must be ≥2.
- `clk` input 1: clock; everything is sampled on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request valid.
- `req_ready` input 1: request ready.
- `req_payload` input payload_width: request payload.
- `resp_valid` input 1: response valid.
- `resp_ready` input 1: response ready.
- `error` output 1: sticky flag, set by the first violation.
- `error_code` output 3: code of the first violation; 0 means none.
- `error_count` output 8: total violations, saturating at 255.
- `outstanding` output clog2(max_outstanding+1): accepted requests not yet answered.

## Operation
- Handshakes:
  - A request handshake (`req_hs`) is `req_valid & req_ready` at a rising edge.
  - A response handshake (`resp_hs`) is `resp_valid & resp_ready` at a rising edge.
- Stall tracking: registers `req_stalled`, `resp_stalled` and `req_payload_q`. Each stalled flag is set at an edge where its valid is 1 and its ready is 0, and cleared otherwise. The payload is captured whenever `req_valid` is 1.
- Violation codes, checked at every edge out of reset:
  - 1 `REQ_CHANGE`: `req_stalled` and `req_valid` and `req_payload != req_payload_q`.
  - 2 `REQ_DROP`: `req_stalled` and `!req_valid`.
  - 3 `RESP_UNDERFLOW`: `resp_hs` while the effective count is 0. The effective count is `outstanding`, plus one if there is a `req_hs` in the same cycle.
  - 4 `OVERFLOW`: `req_hs` without `resp_hs` while `outstanding == max_outstanding`.
  - 5 `TIMEOUT`: see Configuration.
  - 6 `RESP_DROP`: `resp_stalled` and `!resp_valid`.
- Counter update:
  - `req_hs` only: +1, saturating at `max_outstanding` (the overflow is flagged).
  - `resp_hs` only: −1, holding at 0 (the underflow is flagged).
  - Both in the same cycle: unchanged, unless `outstanding == 0`, in which case it becomes 0 with no error (a same-cycle pass-through is legal).
- Multiple violations in one edge:
  - `error_count` increments by 1 per edge, not per violation.
  - `error_code` takes the lowest-numbered code, and only if `error` was 0.
- Once `error` is set, `error` and `error_code` hold until reset. Checking and counting continue.

## Timing
- Reset (`rst` low, asynchronous) clears:
  - `error` = 0, `error_code` = 0, `error_count` = 0, `outstanding` = 0;
  - the stall flags and the timeout counter.
- A violation sampled at edge N is visible on the outputs immediately after edge N (one-edge latency). There are no combinational paths from the inputs to the outputs.
- `outstanding` after edge N reflects the handshakes at edge N.
- Reset asserted mid-transaction discards all state. The first edge after deassertion is a fresh start: no stall history, so no drop or change error can fire at that edge.

## Configuration
- `CHECKER_TIMEOUT_EN` defined: an internal counter, width clog2(timeout_cycles+1), behaves as follows each edge:
  - cleared on any `resp_hs` or when `outstanding == 0`;
  - otherwise incremented;
  - on reaching `timeout_cycles` it flags code 5 once, then holds until it is cleared.
- `CHECKER_TIMEOUT_EN` undefined: there is no counter logic, and code 5 is never produced.

## Test plan
- Legal traffic:
  - Stimulus: 3 back-to-back requests, then 3 responses, with `max_outstanding=4`.
  - Required: `outstanding` goes 1, 2, 3, 2, 1, 0; `error=0` throughout.
- Payload change under stall:
  - Stimulus: `req_valid=1`, `req_ready=0`, payload `0x100` at edge N; payload `0x104` at edge N+1.
  - Required: `error=1` and `error_code=1` after edge N+1; `error_count=1`.
- Response underflow plus a later error:
  - Stimulus: `resp_hs` with `outstanding=0`, then a `REQ_DROP` later.
  - Required: `error_code=3` stays latched; `error_count=2`; `outstanding` stays 0.
- Overflow:
  - Stimulus: 5 request handshakes with no responses, `max_outstanding=4`.
  - Required: `error_code=4` after the 5th; `outstanding=4`.
- Simultaneous handshakes:
  - Stimulus: `req_hs` and `resp_hs` together, once at `outstanding=0` and once at `outstanding=2`.
  - Required: count stays 0 and 2 respectively; no error.
- Timeout, with `CHECKER_TIMEOUT_EN` and `timeout_cycles=8`:
  - Stimulus: one request, then no response for 8 cycles.
  - Required: `error_code=5` at edge 8 after the request; `error_count` stays 1 until a `resp_hs`.
  - Without the macro: `error=0`.

Source files
------------

// File: rtl/checker_bus.sv
// Passive protocol checker for one valid/ready request/response bus: tracks
// outstanding requests and latches the first violation. Optional timeout check: CHECKER_TIMEOUT_EN.
module checker_bus #(
    parameter int payload_width   = 32,
    parameter int max_outstanding = 4,
    parameter int timeout_cycles  = 256
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    input  logic                               req_ready,
    input  logic [payload_width-1:0]           req_payload,
    input  logic                               resp_valid,
    input  logic                               resp_ready,
    output logic                               error,
    output logic [2:0]                         error_code,
    output logic [7:0]                         error_count,
    output logic [$clog2(max_outstanding+1)-1:0] outstanding
);

    localparam int cnt_w = $clog2(max_outstanding + 1);
    localparam logic [cnt_w-1:0] max_o = cnt_w'(max_outstanding);

    logic                     req_hs;
    logic                     resp_hs;
    logic                     req_stalled_reg;
    logic                     resp_stalled_reg;
    logic [payload_width-1:0] req_payload_q_reg;
    logic [cnt_w-1:0]         outstanding_reg;
    logic [cnt_w-1:0]         outstanding_next;
    logic                     error_reg;
    logic [2:0]               error_code_reg;
    logic [2:0]               error_code_next;
    logic [7:0]               error_count_reg;
    logic [6:0]               viol;
    logic [6:0]               first_hot;
    logic                     timeout_hit;

    assign req_hs  = req_valid & req_ready;
    assign resp_hs = resp_valid & resp_ready;

    // Bit index equals the violation code; bit 0 stands for "none" and is tied low.
    assign viol[0] = 1'b0;
    assign viol[1] = req_stalled_reg & req_valid & (req_payload != req_payload_q_reg);
    assign viol[2] = req_stalled_reg & ~req_valid;
    assign viol[3] = resp_hs & ~req_hs & (outstanding_reg == '0);
    assign viol[4] = req_hs & ~resp_hs & (outstanding_reg == max_o);
    assign viol[5] = timeout_hit;
    assign viol[6] = resp_stalled_reg & ~resp_valid;

    genvar gi;
    generate
        for (gi = 1; gi < 7; gi++) begin : g_first
            assign first_hot[gi] = viol[gi] & ~(|viol[gi-1:0]);
        end
    endgenerate
    assign first_hot[0] = 1'b0;

    always_comb begin
        error_code_next = 3'd0;
        for (int i = 1; i < 7; i++) begin
            if (first_hot[i]) begin
                error_code_next = 3'(i);
            end
        end
    end

    // A same-cycle request and response leaves the count untouched, including at zero.
    always_comb begin
        outstanding_next = outstanding_reg;
        if (req_hs && !resp_hs && outstanding_reg != max_o) begin
            outstanding_next = outstanding_reg + 1'b1;
        end else if (resp_hs && !req_hs && outstanding_reg != '0) begin
            outstanding_next = outstanding_reg - 1'b1;
        end
    end

`ifdef CHECKER_TIMEOUT_EN
    localparam int tmo_w = $clog2(timeout_cycles + 1);
    localparam logic [tmo_w-1:0] tmo_max = tmo_w'(timeout_cycles);

    logic [tmo_w-1:0] timeout_cnt_reg;
    logic             timeout_clear;

    assign timeout_clear = resp_hs | (outstanding_reg == '0);
    // Fires only on the edge that reaches the limit; the counter then parks there.
    assign timeout_hit   = ~timeout_clear & (timeout_cnt_reg == tmo_max - 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_cnt_reg <= '0;
        end else if (timeout_clear) begin
            timeout_cnt_reg <= '0;
        end else if (timeout_cnt_reg != tmo_max) begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_stalled_reg   <= 1'b0;
            resp_stalled_reg  <= 1'b0;
            req_payload_q_reg <= '0;
            outstanding_reg   <= '0;
            error_reg         <= 1'b0;
            error_code_reg    <= 3'd0;
            error_count_reg   <= 8'd0;
        end else begin
            req_stalled_reg  <= req_valid & ~req_ready;
            resp_stalled_reg <= resp_valid & ~resp_ready;
            if (req_valid) begin
                req_payload_q_reg <= req_payload;
            end
            outstanding_reg <= outstanding_next;
            if (|viol) begin
                if (!error_reg) begin
                    error_reg      <= 1'b1;
                    error_code_reg <= error_code_next;
                end
                if (error_count_reg != 8'hFF) begin
                    error_count_reg <= error_count_reg + 1'b1;
                end
            end
        end
    end

    assign error       = error_reg;
    assign error_code  = error_code_reg;
    assign error_count = error_count_reg;
    assign outstanding = outstanding_reg;

endmodule

// File: tb/tb_checker_bus.sv
// Scoreboard bench for checker_bus: each step queues the expected outputs, and
// each scenario task compares them against the sampled DUT outputs.
module tb_checker_bus;

    typedef struct packed {
        logic [2:0] outst;
        logic       err;
        logic [2:0] code;
        logic [7:0] cnt;
    } snap_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_payload;
    logic        resp_valid;
    logic        resp_ready;
    logic        error;
    logic [2:0]  error_code;
    logic [7:0]  error_count;
    logic [2:0]  outstanding;

    snap_t exp_q[$];
    snap_t obs_q[$];
    int    checks = 0;
    int    errors = 0;

`ifdef CHECKER_TIMEOUT_EN
    localparam bit to_en = 1'b1;
`else
    localparam bit to_en = 1'b0;
`endif

    checker_bus #(
        .payload_width  (32),
        .max_outstanding(4),
        .timeout_cycles (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_payload(req_payload),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .error      (error),
        .error_code (error_code),
        .error_count(error_count),
        .outstanding(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1);
    end

    function automatic snap_t mk(input int o, input int e, input int c, input int n);
        snap_t s;
        s.outst = 3'(o);
        s.err   = 1'(e);
        s.code  = 3'(c);
        s.cnt   = 8'(n);
        return s;
    endfunction

    task automatic step(input logic rv, input logic rr, input logic [31:0] pl,
                        input logic sv, input logic sr, input snap_t exp);
        snap_t s;
        req_valid   = rv;
        req_ready   = rr;
        req_payload = pl;
        resp_valid  = sv;
        resp_ready  = sr;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        s.outst = outstanding;
        s.err   = error;
        s.code  = error_code;
        s.cnt   = error_count;
        obs_q.push_back(s);
    endtask

    task automatic idle_inputs();
        req_valid   = 1'b0;
        req_ready   = 1'b0;
        req_payload = 32'h0;
        resp_valid  = 1'b0;
        resp_ready  = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #12;
        checks++;
        if ({error, error_code, error_count, outstanding} !== 15'd0) begin
            errors++;
            $display("FAIL reset got err=%0d code=%0d cnt=%0d out=%0d want all 0",
                     error, error_code, error_count, outstanding);
        end else begin
            $display("reset ok err=0 code=0 cnt=0 out=0");
        end
        rst = 1'b1;
        // Mid-transaction reset: stall history must be discarded.
        step(1, 1, 32'h10, 0, 0, mk(1, 0, 0, 0));
        step(1, 0, 32'h14, 0, 0, mk(1, 0, 0, 0));
        rst = 1'b0;
        #2;
        rst = 1'b1;
        step(0, 0, 32'h0, 0, 0, mk(0, 0, 0, 0));
        step(0, 0, 32'h0, 0, 0, mk(0, 0, 0, 0));
        for (int i = 0; exp_q.size() != 0; i++) begin
            snap_t e = exp_q.pop_front();
            snap_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid[%0d] got out=%0d err=%0d code=%0d cnt=%0d want out=%0d err=%0d code=%0d cnt=%0d",
                         i, o.outst, o.err, o.code, o.cnt, e.outst, e.err, e.code, e.cnt);
            end else $display("reset_mid[%0d] ok out=%0d err=%0d", i, o.outst, o.err);
        end
    endtask

    task automatic test_legal();
        apply_reset();
        step(1, 1, 32'hA0, 0, 0, mk(1, 0, 0, 0));
        step(1, 1, 32'hA4, 0, 0, mk(2, 0, 0, 0));
        step(1, 1, 32'hA8, 0, 0, mk(3, 0, 0, 0));
        step(0, 0, 32'h0, 1, 1, mk(2, 0, 0, 0));
        step(0, 0, 32'h0, 1, 1, mk(1, 0, 0, 0));
        step(0, 0, 32'h0, 1, 1, mk(0, 0, 0, 0));
        for (int i = 0; exp_q.size() != 0; i++) begin
            snap_t e = exp_q.pop_front();
            snap_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL legal[%0d] got out=%0d err=%0d code=%0d cnt=%0d want out=%0d err=%0d code=%0d cnt=%0d",
                         i, o.outst, o.err, o.code, o.cnt, e.outst, e.err, e.code, e.cnt);
            end else $display("legal[%0d] ok out=%0d err=%0d", i, o.outst, o.err);
        end
    endtask

    task automatic test_req_change();
        apply_reset();
        step(1, 0, 32'h100, 0, 0, mk(0, 0, 0, 0));
        step(1, 0, 32'h104, 0, 0, mk(0, 1, 1, 1));
        step(1, 1, 32'h104, 0, 0, mk(1, 1, 1, 1));
        step(0, 0, 32'h0, 0, 0, mk(1, 1, 1, 1));
        for (int i = 0; exp_q.size() != 0; i++) begin
            snap_t e = exp_q.pop_front();
            snap_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL req_change[%0d] got out=%0d err=%0d code=%0d cnt=%0d want out=%0d err=%0d code=%0d cnt=%0d",
                         i, o.outst, o.err, o.code, o.cnt, e.outst, e.err, e.code, e.cnt);
            end else $display("req_change[%0d] ok code=%0d cnt=%0d", i, o.code, o.cnt);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        step(0, 0, 32'h0, 1, 1, mk(0, 1, 3, 1));
        step(1, 0, 32'h5, 0, 0, mk(0, 1, 3, 1));
        step(0, 0, 32'h0, 0, 0, mk(0, 1, 3, 2));
        step(0, 0, 32'h0, 0, 0, mk(0, 1, 3, 2));
        // Response stalled then withdrawn: RESP_DROP counts but code stays 3.
        step(0, 0, 32'h0, 1, 0, mk(0, 1, 3, 2));
        step(0, 0, 32'h0, 0, 0, mk(0, 1, 3, 3));
        for (int i = 0; exp_q.size() != 0; i++) begin
            snap_t e = exp_q.pop_front();
            snap_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL underflow[%0d] got out=%0d err=%0d code=%0d cnt=%0d want out=%0d err=%0d code=%0d cnt=%0d",
                         i, o.outst, o.err, o.code, o.cnt, e.outst, e.err, e.code, e.cnt);
            end else $display("underflow[%0d] ok code=%0d cnt=%0d", i, o.code, o.cnt);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        step(1, 1, 32'h1, 0, 0, mk(1, 0, 0, 0));
        step(1, 1, 32'h2, 0, 0, mk(2, 0, 0, 0));
        step(1, 1, 32'h3, 0, 0, mk(3, 0, 0, 0));
        step(1, 1, 32'h4, 0, 0, mk(4, 0, 0, 0));
        step(1, 1, 32'h5, 0, 0, mk(4, 1, 4, 1));
        step(0, 0, 32'h0, 0, 0, mk(4, 1, 4, 1));
        for (int i = 0; exp_q.size() != 0; i++) begin
            snap_t e = exp_q.pop_front();
            snap_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL overflow[%0d] got out=%0d err=%0d code=%0d cnt=%0d want out=%0d err=%0d code=%0d cnt=%0d",
                         i, o.outst, o.err, o.code, o.cnt, e.outst, e.err, e.code, e.cnt);
            end else $display("overflow[%0d] ok out=%0d code=%0d", i, o.outst, o.code);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        step(1, 1, 32'h20, 1, 1, mk(0, 0, 0, 0));
        step(1, 1, 32'h24, 0, 0, mk(1, 0, 0, 0));
        step(1, 1, 32'h28, 0, 0, mk(2, 0, 0, 0));
        step(1, 1, 32'h2C, 1, 1, mk(2, 0, 0, 0));
        step(0, 0, 32'h0, 0, 0, mk(2, 0, 0, 0));
        for (int i = 0; exp_q.size() != 0; i++) begin
            snap_t e = exp_q.pop_front();
            snap_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d] got out=%0d err=%0d code=%0d cnt=%0d want out=%0d err=%0d code=%0d cnt=%0d",
                         i, o.outst, o.err, o.code, o.cnt, e.outst, e.err, e.code, e.cnt);
            end else $display("back_to_back[%0d] ok out=%0d err=%0d", i, o.outst, o.err);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        step(1, 1, 32'h40, 0, 0, mk(1, 0, 0, 0));
        for (int k = 1; k <= 11; k++) begin
            if (to_en && k >= 8) step(0, 0, 32'h0, 0, 0, mk(1, 1, 5, 1));
            else                 step(0, 0, 32'h0, 0, 0, mk(1, 0, 0, 0));
        end
        if (to_en) step(0, 0, 32'h0, 1, 1, mk(0, 1, 5, 1));
        else       step(0, 0, 32'h0, 1, 1, mk(0, 0, 0, 0));
        for (int i = 0; exp_q.size() != 0; i++) begin
            snap_t e = exp_q.pop_front();
            snap_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL timeout[%0d] got out=%0d err=%0d code=%0d cnt=%0d want out=%0d err=%0d code=%0d cnt=%0d",
                         i, o.outst, o.err, o.code, o.cnt, e.outst, e.err, e.code, e.cnt);
            end else $display("timeout[%0d] ok err=%0d code=%0d cnt=%0d", i, o.err, o.code, o.cnt);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_legal();
        test_req_change();
        test_underflow();
        test_overflow();
        test_back_to_back();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
